// File: rtl/aes_round_stage.sv
// Registered AES-128 round datapath: ShiftRows -> MixColumns -> AddRoundKey, one register per stage.
// Optional macro AES_ROUND_INITIAL_EN adds an initial_round port that makes both stages pass through (round-0 whitening).
module aes_round_stage (
  input  logic         clk,
  input  logic         rst,
  input  logic         enable,
  input  logic         load,
  input  logic [127:0] state,
  input  logic [127:0] key,
  input  logic         final_round,
`ifdef AES_ROUND_INITIAL_EN
  input  logic         initial_round,
`endif
  output logic [127:0] state_out,
  output logic         done
);

  localparam int unsigned BLK_W  = 128;
  localparam int unsigned BYTE_W = 8;
  localparam int unsigned COL_W  = 32;
  localparam int unsigned N_ROW  = 4;
  localparam int unsigned N_COL  = 4;

  function automatic logic [BYTE_W-1:0] xtime(input logic [BYTE_W-1:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Byte k = row (k mod 4), column (k div 4); out[r][c] = in[r][(c+r) mod 4]
  function automatic logic [BLK_W-1:0] shift_rows(input logic [BLK_W-1:0] s);
    logic [BLK_W-1:0] o;
    o = '0;
    for (int c = 0; c < int'(N_COL); c++) begin
      for (int r = 0; r < int'(N_ROW); r++) begin
        o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c+r)%4)+r) -: 8];
      end
    end
    return o;
  endfunction

  function automatic logic [COL_W-1:0] mix_column(input logic [COL_W-1:0] col);
    logic [BYTE_W-1:0] a0, a1, a2, a3;
    logic [BYTE_W-1:0] o0, o1, o2, o3;
    a0 = col[31:24];
    a1 = col[23:16];
    a2 = col[15:8];
    a3 = col[7:0];
    o0 = xtime(a0) ^ (xtime(a1) ^ a1) ^ a2 ^ a3;
    o1 = a0 ^ xtime(a1) ^ (xtime(a2) ^ a2) ^ a3;
    o2 = a0 ^ a1 ^ xtime(a2) ^ (xtime(a3) ^ a3);
    o3 = (xtime(a0) ^ a0) ^ a1 ^ a2 ^ xtime(a3);
    return {o0, o1, o2, o3};
  endfunction

  function automatic logic [BLK_W-1:0] mix_columns(input logic [BLK_W-1:0] s);
    logic [BLK_W-1:0] o;
    o = '0;
    for (int c = 0; c < int'(N_COL); c++) begin
      o[127-32*c -: 32] = mix_column(s[127-32*c -: 32]);
    end
    return o;
  endfunction

  logic             stage1_en_c;
  logic [BLK_W-1:0] sr_c;
  logic [BLK_W-1:0] mc_c;

  logic             s1_done;
  logic [BLK_W-1:0] s1_state;
  logic [BLK_W-1:0] s1_key;
  logic             s1_final;
  logic             s2_done;
  logic [BLK_W-1:0] s2_state;
  logic [BLK_W-1:0] s2_key;
`ifdef AES_ROUND_INITIAL_EN
  logic             s1_init;
`endif

  assign stage1_en_c = enable & ~load;

  // Stage 1/2 combinational transforms; whitening requests skip both
  always_comb begin
    sr_c = shift_rows(state);
    mc_c = mix_columns(s1_state);
`ifdef AES_ROUND_INITIAL_EN
    if (initial_round) sr_c = state;
    if (s1_init || s1_final) mc_c = s1_state;
`else
    if (s1_final) mc_c = s1_state;
`endif
  end

  // Key and round flags ride along with their state so late input changes cannot corrupt accepted requests
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_done   <= 1'b0;
      s1_state  <= '0;
      s1_key    <= '0;
      s1_final  <= 1'b0;
      s2_done   <= 1'b0;
      s2_state  <= '0;
      s2_key    <= '0;
      done      <= 1'b0;
      state_out <= '0;
`ifdef AES_ROUND_INITIAL_EN
      s1_init   <= 1'b0;
`endif
    end else begin
      s1_done <= stage1_en_c;
      if (stage1_en_c) begin
        s1_state <= sr_c;
        s1_key   <= key;
        s1_final <= final_round;
`ifdef AES_ROUND_INITIAL_EN
        s1_init  <= initial_round;
`endif
      end
      s2_done <= s1_done;
      if (s1_done) begin
        s2_state <= mc_c;
        s2_key   <= s1_key;
      end
      done <= s2_done;
      if (s2_done) state_out <= s2_state ^ s2_key;
    end
  end

endmodule

// File: tb/tb_aes_round_stage.sv
// Directed-vector bench for aes_round_stage using FIPS-197 round values and a 3-deep expected-result pipe.
module tb_aes_round_stage;

  localparam logic [127:0] V1S  = 128'hd42711aee0bf98f1b8b45de51e415230;
  localparam logic [127:0] V1K  = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] V1E  = 128'ha49c7ff2689f352b6b5bea43026a5049;
  localparam logic [127:0] V1SR = 128'hd4bf5d30e0b452aeb84111f11e2798e5;
  localparam logic [127:0] V1MC = 128'h046681e5e0cb199a48f8d37a2806264c;
  localparam logic [127:0] V2S  = 128'he9098972cb31075f3d327d94af2e2cb5;
  localparam logic [127:0] V2K  = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] V2E  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] COLS = 128'hdb000000_00130000_00005300_00000045;
  localparam logic [127:0] COLE = 128'h8e4da1bc_00000000_00000000_00000000;
  localparam logic [127:0] JUNK = 128'h0123456789abcdeffedcba9876543210;

  logic         clk = 1'b0;
  logic         rst, enable, load, final_round;
  logic [127:0] state, key;
  logic [127:0] state_out;
  logic         done;
`ifdef AES_ROUND_INITIAL_EN
  logic         initial_round = 1'b0;
`endif

  always #5 clk = ~clk;

  aes_round_stage dut (
    .clk         (clk),
    .rst         (rst),
    .enable      (enable),
    .load        (load),
    .state       (state),
    .key         (key),
    .final_round (final_round),
`ifdef AES_ROUND_INITIAL_EN
    .initial_round (initial_round),
`endif
    .state_out   (state_out),
    .done        (done)
  );

  int n_vec  = 0;
  int n_miss = 0;

  logic [2:0]   mv = '0;
  logic [127:0] md [3];
  logic [127:0] last_out = '0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Drive one cycle, advance the expected pipe, then compare done and state_out
  task automatic step(input logic rs, input logic en, input logic ld, input logic fr,
                      input logic [127:0] st, input logic [127:0] k, input logic [127:0] ex);
    rst = rs; enable = en; load = ld; final_round = fr; state = st; key = k;
    @(posedge clk);
    #1;
    if (rs) begin
      mv = '0;
      for (int i = 0; i < 3; i++) md[i] = '0;
      last_out = '0;
    end else begin
      mv = {mv[1:0], en & ~ld};
      md[2] = md[1];
      md[1] = md[0];
      md[0] = ex;
    end
    check("done", 128'(done), 128'(mv[2]));
    if (mv[2]) last_out = md[2];
    check("state_out", state_out, last_out);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b1, JUNK, JUNK, '0);
  endtask

  initial begin
    for (int i = 0; i < 3; i++) md[i] = '0;
    step(1'b1, 1'b0, 1'b0, 1'b0, '0, '0, '0);
    step(1'b1, 1'b1, 1'b0, 1'b0, V1S, V1K, V1E);

    // single round-1 request, inputs scrambled while it is in flight
    step(1'b0, 1'b1, 1'b0, 1'b0, V1S, V1K, V1E);
    check("shift_rows", dut.s1_state, V1SR);
    step(1'b0, 1'b0, 1'b0, 1'b1, JUNK, JUNK, '0);
    check("mix_columns", dut.s2_state, V1MC);
    idle(3);

    // final round bypasses MixColumns
    step(1'b0, 1'b1, 1'b0, 1'b1, V2S, V2K, V2E);
    idle(4);

    // single MixColumns column
    step(1'b0, 1'b1, 1'b0, 1'b0, COLS, '0, COLE);
    idle(3);

    // alternating stream with one load bubble
    for (int i = 0; i < 10; i++) begin
      if (i % 2 == 1) step(1'b0, 1'b1, i == 5, 1'b1, V2S, V2K, V2E);
      else            step(1'b0, 1'b1, i == 5, 1'b0, V1S, V1K, V1E);
    end
    idle(4);

    // reset with two requests in flight, enable still high on the reset edge
    step(1'b0, 1'b1, 1'b0, 1'b0, V1S, V1K, V1E);
    step(1'b0, 1'b1, 1'b0, 1'b1, V2S, V2K, V2E);
    step(1'b1, 1'b1, 1'b0, 1'b0, V1S, V1K, V1E);
    idle(4);

`ifdef AES_ROUND_INITIAL_EN
    initial_round = 1'b1;
    step(1'b0, 1'b1, 1'b0, 1'b1, 128'h3243f6a8885a308d313198a2e0370734,
         128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h193de3bea0f4e22b9ac68d2ae9f84808);
    initial_round = 1'b0;
    idle(2);
    step(1'b0, 1'b1, 1'b0, 1'b0, V1S, V1K, V1E);
    idle(4);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
